// File: rtl/pat_pc_sequencer.sv
// Program counter and hardware return-address stack for the pat processor.
// Registered next-PC selection with condition-gated branch/call/return, stall and sticky errors.
module pat_pc_sequencer #(
  parameter int unsigned i_adr_width     = 10,
  parameter int unsigned offset_width    = 8,
  parameter int unsigned stack_depth     = 8,
  parameter int unsigned stack_ptr_width = 3,
  parameter int unsigned reset_vector    = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       op_bf,
  input  logic                       op_bb,
  input  logic                       op_call,
  input  logic                       op_return,
  input  logic                       cond_true,
  input  logic [offset_width-1:0]    offset,
  input  logic                       err_clr,
  output logic [i_adr_width-1:0]     pc,
  output logic [stack_ptr_width:0]   depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int unsigned AW = i_adr_width;
  localparam int unsigned DW = stack_ptr_width + 1;
  localparam int unsigned PW = stack_ptr_width;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RET,
    SEL_CALL,
    SEL_BF,
    SEL_BB
  } op_sel_t;

  op_sel_t          op_sel_c;
  logic [AW-1:0]    pc_inc_c;
  logic [AW-1:0]    off_ext_c;
  logic [AW-1:0]    ret_addr_c;
  logic [PW-1:0]    top_idx_c;
  logic             is_full_c;
  logic             is_empty_c;

  logic [AW-1:0]    pc_next;
  logic [DW-1:0]    depth_next;
  logic             full_next;
  logic             empty_next;
  logic             ovf_next;
  logic             unf_next;
  logic             push_c;

  logic [AW-1:0]    stack_mem [stack_depth];

  // Fixed-priority strobe decode: return > call > branch forward > branch backward.
  always_comb begin
    op_sel_c = SEL_NONE;
    if (op_return)    op_sel_c = SEL_RET;
    else if (op_call) op_sel_c = SEL_CALL;
    else if (op_bf)   op_sel_c = SEL_BF;
    else if (op_bb)   op_sel_c = SEL_BB;
  end

  assign pc_inc_c   = pc + AW'(1);
  assign off_ext_c  = AW'(offset);
  assign top_idx_c  = PW'(depth - DW'(1));
  assign ret_addr_c = stack_mem[top_idx_c];
  assign is_full_c  = (depth == DW'(stack_depth));
  assign is_empty_c = (depth == '0);

  // Next-state selection; errors are cleared first so a same-cycle event wins.
  always_comb begin
    pc_next    = pc_inc_c;
    depth_next = depth;
    ovf_next   = overflow_err;
    unf_next   = underflow_err;
    push_c     = 1'b0;

    if (stall) begin
      pc_next = pc;
    end else begin
      if (err_clr) begin
        ovf_next = 1'b0;
        unf_next = 1'b0;
      end
      if (cond_true) begin
        case (op_sel_c)
          SEL_RET: begin
            if (is_empty_c) begin
              unf_next = 1'b1;
            end else begin
              pc_next    = ret_addr_c;
              depth_next = depth - DW'(1);
            end
          end
          SEL_CALL: begin
            if (is_full_c) begin
              ovf_next = 1'b1;
            end else begin
              push_c     = 1'b1;
              pc_next    = pc + off_ext_c;
              depth_next = depth + DW'(1);
            end
          end
          SEL_BF:   pc_next = pc + off_ext_c;
          SEL_BB:   pc_next = pc - off_ext_c;
          default:  pc_next = pc_inc_c;
        endcase
      end
    end

    full_next  = (depth_next == DW'(stack_depth));
    empty_next = (depth_next == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= AW'(reset_vector);
      depth         <= '0;
      stack_full    <= 1'b0;
      stack_empty   <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      pc            <= pc_next;
      depth         <= depth_next;
      stack_full    <= full_next;
      stack_empty   <= empty_next;
      overflow_err  <= ovf_next;
      underflow_err <= unf_next;
    end
  end

  // Return-address storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      stack_mem[depth[PW-1:0]] <= pc_inc_c;
    end
  end

endmodule

// File: tb/tb_pat_pc_sequencer.sv
// Self-checking bench for pat_pc_sequencer: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pat_pc_sequencer;

  localparam int AW   = 10;
  localparam int SD   = 8;
  localparam int MODV = 1 << AW;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall, op_bf, op_bb, op_call, op_return, cond_true, err_clr;
  logic [7:0]      offset;
  logic [AW-1:0]   pc;
  logic [3:0]      depth;
  logic            stack_full, stack_empty, overflow_err, underflow_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_pc;
  int q[$];
  bit m_ovf, m_unf;

  pat_pc_sequencer #(
    .i_adr_width(AW), .offset_width(8), .stack_depth(SD),
    .stack_ptr_width(3), .reset_vector(0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .op_bf(op_bf), .op_bb(op_bb),
    .op_call(op_call), .op_return(op_return), .cond_true(cond_true),
    .offset(offset), .err_clr(err_clr), .pc(pc), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st, bf, bb, call, ret, cond, clr;
    int off;
    int e_pc, e_depth;
    bit e_ovf, e_unf;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(bit st, bit bf, bit bb, bit call, bit ret, bit cond, int off,
                              bit clr, int e_pc, int e_depth, bit e_ovf, bit e_unf);
    vec_t v;
    v.st = st; v.bf = bf; v.bb = bb; v.call = call; v.ret = ret; v.cond = cond;
    v.off = off; v.clr = clr; v.e_pc = e_pc; v.e_depth = e_depth;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  // Architectural behaviour from the rules: priority select, queue as LIFO stack.
  function automatic void model_step(bit st, bit bf, bit bb, bit call, bit ret, bit cond,
                                     int off, bit clr);
    bit set_o = 1'b0;
    bit set_u = 1'b0;
    int nxt = (m_pc + 1) % MODV;
    if (st) return;
    if (ret) begin
      if (cond) begin
        if (q.size() > 0) nxt = q.pop_back();
        else set_u = 1'b1;
      end
    end else if (call) begin
      if (cond) begin
        if (q.size() < SD) begin
          q.push_back((m_pc + 1) % MODV);
          nxt = (m_pc + off) % MODV;
        end else set_o = 1'b1;
      end
    end else if (bf) begin
      if (cond) nxt = (m_pc + off) % MODV;
    end else if (bb) begin
      if (cond) nxt = (m_pc - off + MODV) % MODV;
    end
    m_pc = nxt;
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (set_o) m_ovf = 1'b1;
    if (set_u) m_unf = 1'b1;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_pc"}, int'(pc), m_pc);
    chk({tag, "_depth"}, int'(depth), q.size());
    chk({tag, "_full"}, int'(stack_full), int'(q.size() == SD));
    chk({tag, "_empty"}, int'(stack_empty), int'(q.size() == 0));
    chk({tag, "_ovf"}, int'(overflow_err), int'(m_ovf));
    chk({tag, "_unf"}, int'(underflow_err), int'(m_unf));
  endtask

  // Drive one cycle's inputs just after an edge, advance one clock, then compare.
  task automatic step(input bit st, input bit bf, input bit bb, input bit call, input bit ret,
                      input bit cond, input int off, input bit clr, input string tag);
    stall = st; op_bf = bf; op_bb = bb; op_call = call; op_return = ret;
    cond_true = cond; offset = 8'(off); err_clr = clr;
    @(posedge clk);
    #1;
    model_step(st, bf, bb, call, ret, cond, off, clr);
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    int base;
    int r1, r2, r3;

    vt[0]  = mk(0,0,0,0,0,0,  0,0,    1,0,0,0);
    vt[1]  = mk(0,0,0,0,0,0,  0,0,    2,0,0,0);
    vt[2]  = mk(0,0,0,0,0,0,  0,0,    3,0,0,0);
    vt[3]  = mk(0,0,1,0,0,1,  3,0,    0,0,0,0);
    vt[4]  = mk(0,1,0,0,0,1, 10,0,   10,0,0,0);
    vt[5]  = mk(0,1,0,0,0,1,  5,0,   15,0,0,0);
    vt[6]  = mk(0,0,1,0,0,1, 20,0, 1019,0,0,0);
    vt[7]  = mk(0,1,0,0,0,0,  5,0, 1020,0,0,0);
    vt[8]  = mk(0,1,0,0,0,1,104,0,  100,0,0,0);
    vt[9]  = mk(0,0,0,1,0,1, 50,0,  150,1,0,0);
    vt[10] = mk(0,0,0,0,1,1,  0,0,  101,0,0,0);
    vt[11] = mk(0,0,0,0,1,1,  0,0,  102,0,0,1);
    vt[12] = mk(0,0,0,0,0,0,  0,1,  103,0,0,0);
    vt[13] = mk(0,0,0,1,0,0, 10,0,  104,0,0,0);
    vt[14] = mk(0,0,0,1,0,1, 10,0,  114,1,0,0);
    vt[15] = mk(1,0,0,1,0,1, 10,0,  114,1,0,0);
    vt[16] = mk(0,0,0,1,1,1, 10,0,  105,0,0,0);

    stall = 0; op_bf = 0; op_bb = 0; op_call = 0; op_return = 0;
    cond_true = 0; offset = '0; err_clr = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vt[i].st, vt[i].bf, vt[i].bb, vt[i].call, vt[i].ret, vt[i].cond,
           vt[i].off, vt[i].clr, "vec_model");
      chk($sformatf("vec%0d_pc", i), int'(pc), vt[i].e_pc);
      chk($sformatf("vec%0d_depth", i), int'(depth), vt[i].e_depth);
      chk($sformatf("vec%0d_ovf", i), int'(overflow_err), int'(vt[i].e_ovf));
      chk($sformatf("vec%0d_unf", i), int'(underflow_err), int'(vt[i].e_unf));
    end

    // Nested calls return in LIFO order
    base = m_pc;
    step(0, 0, 0, 1, 0, 1, 10, 0, "nest_c1");
    step(0, 0, 0, 1, 0, 1, 20, 0, "nest_c2");
    step(0, 0, 0, 1, 0, 1, 30, 0, "nest_c3");
    chk("nest_depth3", int'(depth), 3);
    step(0, 0, 0, 0, 1, 1, 0, 0, "nest_r1");
    r1 = int'(pc);
    step(0, 0, 0, 0, 1, 1, 0, 0, "nest_r2");
    r2 = int'(pc);
    step(0, 0, 0, 0, 1, 1, 0, 0, "nest_r3");
    r3 = int'(pc);
    chk("nest_ret1", r1, (base + 31) % MODV);
    chk("nest_ret2", r2, (base + 11) % MODV);
    chk("nest_ret3", r3, (base + 1) % MODV);

    // Fill to full, overflow, clear, clear-vs-set
    for (int i = 0; i < SD; i++) step(0, 0, 0, 1, 0, 1, 1, 0, "fill");
    chk("full_flag", int'(stack_full), 1);
    base = m_pc;
    step(0, 0, 0, 1, 0, 1, 7, 0, "ovf_call");
    chk("ovf_pc", int'(pc), (base + 1) % MODV);
    chk("ovf_depth", int'(depth), SD);
    chk("ovf_flag", int'(overflow_err), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, "ovf_clr");
    chk("ovf_cleared", int'(overflow_err), 0);
    step(0, 0, 0, 1, 0, 1, 7, 1, "ovf_setwins");
    chk("ovf_set_wins", int'(overflow_err), 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, "ovf_stall_clr");
    chk("ovf_stall_hold", int'(overflow_err), 1);
    for (int i = 0; i < SD; i++) step(0, 0, 0, 0, 1, 1, 0, 0, "drain");
    chk("drain_empty", int'(stack_empty), 1);

    // Asynchronous reset in the middle of a call cycle
    step(0, 0, 0, 1, 0, 1, 40, 0, "pre_arst");
    stall = 0; op_call = 1; cond_true = 1; offset = 8'd40; err_clr = 0;
    #1 reset = 1'b0;
    #1;
    chk("arst_pc", int'(pc), 0);
    chk("arst_depth", int'(depth), 0);
    chk("arst_empty", int'(stack_empty), 1);
    chk("arst_ovf", int'(overflow_err), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    check_model("arst_hold");

    // Underflow at pc=40
    step(0, 1, 0, 0, 0, 1, 40, 0, "to40");
    chk("to40_pc", int'(pc), 40);
    step(0, 0, 0, 0, 1, 1, 0, 0, "unf");
    chk("unf_pc", int'(pc), 41);
    chk("unf_flag", int'(underflow_err), 1);
    chk("unf_depth", int'(depth), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 10) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
           ($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 5) != 0,
           int'($urandom % 256), ($urandom % 12) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pat_pc_sequencer.md
Name: pat_pc_sequencer

Overview:
Parametrised program-counter and call-stack unit for the pat processor. Replaces the combinational next-PC selector plus ad-hoc call stack with one registered block that owns pc, a hardware return-address stack of configurable depth, condition-gated branch/call/return, stall, and sticky overflow/underflow error flags. Sits between the instruction decoder (op strobes, condition result, immediate offset) and the instruction-memory address input.

Parameters:
i_adr_width, 10, instruction address width (pc width)
offset_width, 8, width of branch/call immediate offset, zero-extended
stack_depth, 8, number of return-address entries
stack_ptr_width, 3, log2(stack_depth); stack_depth must equal 2**stack_ptr_width
reset_vector, 0, pc value loaded on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
stall  input  1  1 = hold all state this cycle
op_bf  input  1  branch forward: pc + offset
op_bb  input  1  branch backward: pc - offset
op_call  input  1  push pc+1, jump to pc + offset
op_return  input  1  pop return address into pc
cond_true  input  1  condition code result; op takes effect only when 1
offset  input  offset_width  immediate offset
err_clr  input  1  clears sticky error flags
pc  output  i_adr_width  current program counter
depth  output  stack_ptr_width+1  number of valid stack entries, 0..stack_depth
stack_full  output  1  depth == stack_depth
stack_empty  output  1  depth == 0
overflow_err  output  1  sticky: call attempted while full
underflow_err  output  1  sticky: return attempted while empty

Behaviour:
- Reset (reset low, asynchronous): pc = reset_vector, depth = 0, overflow_err = 0, underflow_err = 0. Stack RAM contents not reset. Release synchronous to clk by system.
- All state updates on rising clk; pc output is the register (no combinational path from inputs to pc).
- stall = 1: pc, depth, stack, error flags all hold; err_clr ignored.
- Op priority when more than one strobe asserted: op_return > op_call > op_bf > op_bb; lower-priority strobes ignored.
- "Taken" = selected op asserted and cond_true = 1. Not taken or no op: pc <= pc + 1.
- op_bf taken: pc <= pc + zext(offset). op_bb taken: pc <= pc - zext(offset).
- op_call taken, not full: stack[depth] <= pc + 1; depth += 1; pc <= pc + zext(offset).
- op_call taken, full: no push, depth unchanged, overflow_err <= 1, pc <= pc + 1.
- op_return taken, not empty: pc <= stack[depth-1]; depth -= 1.
- op_return taken, empty: underflow_err <= 1, depth stays 0, pc <= pc + 1.
- All pc arithmetic modulo 2**i_adr_width (wraps silently, including return address pc+1 at top of space).
- Error flags: set by event, held until err_clr = 1 on a non-stalled cycle; set and clear in same cycle -> set wins.
- Not-taken call/return never touches stack or flags.
- Return latency: return address visible on pc one cycle after the return strobe; call followed immediately by return (back-to-back) returns to call-site+1.
- Reset mid-call/return: asynchronous reset overrides everything immediately.

Test Plan:
- Reset: hold reset low, reset_vector=0 -> pc=0, depth=0, stack_empty=1, both errors 0; release, 3 idle cycles -> pc=1,2,3.
- Branches: pc=10, op_bf offset=5 cond=1 -> pc=15; op_bb offset=20 cond=1 at pc=15 -> pc=1019 (wrap, width 10); op_bf cond=0 -> pc+1.
- Call/return: pc=100, op_call offset=50 -> pc=150, depth=1; next cycle op_return -> pc=101, depth=0; nested 3 calls then 3 returns restore addresses in LIFO order.
- Overflow: 8 calls fill stack (stack_full=1); 9th call at pc=P -> pc=P+1, depth=8, overflow_err=1; err_clr -> 0; err_clr concurrent with another overflowing call -> stays 1.
- Underflow: empty stack, op_return cond=1 at pc=40 -> pc=41, underflow_err=1, depth=0.
- Stall and priority: stall=1 with op_call -> nothing changes; op_return+op_call together with depth=1 -> pop only, depth=0; async reset asserted mid-cycle during call -> pc=reset_vector immediately, depth=0.
